// File: rtl/fetch_queue.sv
// fetch_queue
// Instruction fetch queue between the fetch stage and decode. Show-ahead FIFO
// of {instruction, PC} pairs with a flush that discards every queued entry and
// keeps a saturating tally of how many entries were thrown away.
//
// Ports
//   clk          rising-edge clock for all state
//   rst_n        asynchronous active-low reset
//   flush        discard all queued entries (branch/halt redirect)
//   in_valid     fetch stage presents an entry
//   in_ready     queue accepts an entry this cycle (count != DEPTH)
//   in_instr     instruction word
//   in_pc        PC of in_instr
//   out_valid    head entry valid toward decode (count != 0)
//   out_ready    decode consumes the head entry
//   out_instr    head instruction word
//   out_pc       head PC
//   count        current occupancy
//   flushed_cnt  saturating count of entries discarded by flush
module fetch_queue #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_instr,
    input  logic [PC_W-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_instr,
    output logic [PC_W-1:0]          out_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               flushed_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    generate
        if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("fetch_queue: DEPTH must be a power of two between 2 and 16");
        end
    endgenerate

    logic [DATA_W-1:0] mem_instr [DEPTH];
    logic [PC_W-1:0]   mem_pc    [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [7:0]    flushed_q;
    // Set on the first edge after reset release; pushes are held off until
    // then so the queue never captures data on the release edge itself.
    logic          run_q;

    logic          push;
    logic          pop;
    logic [9:0]    flush_sum;

    assign in_ready    = (count_q != CW'(DEPTH));
    assign out_valid   = (count_q != '0);
    assign count       = count_q;
    assign flushed_cnt = flushed_q;

    assign push = in_valid && in_ready && !flush && run_q;
    assign pop  = out_valid && out_ready && !flush;

    // Wide enough for 255 + DEPTH + 1 so the saturation compare cannot wrap.
    assign flush_sum = {2'b00, flushed_q} + 10'(count_q) + 10'(in_valid && in_ready);

    assign out_instr = mem_instr[rd_ptr];
    assign out_pc    = mem_pc[rd_ptr];

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= in_instr;
            mem_pc[wr_ptr]    <= in_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            flushed_q <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            flushed_q <= (flush_sum > 10'd255) ? 8'd255 : flush_sum[7:0];
        end else begin
            // DEPTH is a power of two, so natural pointer overflow wraps
            // DEPTH-1 back to 0.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
